// File: rtl/key_debounce.sv
// key_debounce: conditions raw push-button pins into clean, synchronous
// key events. Each key is handled independently:
//   pin -> 2-flop synchroniser -> polarity normalisation -> counter debounce
//   -> press/release pulses -> hold FSM (long press, auto-repeat).
// Every output is a flop; there is no combinational path from key_in.
module key_debounce #(
  parameter int KEY_NUM        = 4,
  parameter int DEBOUNCE_CYC   = 4000000,
  parameter int LONG_CYC       = 200000000,
  parameter int REPEAT_CYC     = 40000000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  // Counter widths sized so the terminal value (N-1) always fits.
  localparam int DB_W  = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int LNG_W = (LONG_CYC     > 2) ? $clog2(LONG_CYC)     : 1;
  localparam int REP_W = (REPEAT_CYC   > 2) ? $clog2(REPEAT_CYC)   : 1;

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [LNG_W-1:0] LNG_MAX = LNG_W'(LONG_CYC - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYC - 1);
  localparam logic [LNG_W-1:0] LNG_ONE = LNG_W'(1);
  localparam logic [LNG_W-1:0] LNG_ZERO = '0;
  localparam logic [REP_W-1:0] REP_ZERO = '0;
  localparam logic [DB_W-1:0]  DB_ZERO  = '0;

  // Pin level of a released key; the synchroniser resets to it so that no
  // spurious press is seen when reset is released with all keys idle.
  localparam logic [KEY_NUM-1:0] PIN_IDLE = {KEY_NUM{KEY_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_st_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [KEY_NUM-1:0] pressed_s;             // normalised level, 1 = pressed

  logic [DB_W-1:0]    db_cnt_q  [KEY_NUM];
  logic [DB_W-1:0]    db_cnt_d  [KEY_NUM];
  logic [KEY_NUM-1:0] key_state_q, key_state_d;
  logic [KEY_NUM-1:0] key_press_q, key_press_d;
  logic [KEY_NUM-1:0] key_release_q, key_release_d;

  hold_st_e           hold_st_q [KEY_NUM];
  hold_st_e           hold_st_d [KEY_NUM];
  logic [LNG_W-1:0]   hold_cnt_q [KEY_NUM];
  logic [LNG_W-1:0]   hold_cnt_d [KEY_NUM];
  logic [REP_W-1:0]   rep_cnt_q  [KEY_NUM];
  logic [REP_W-1:0]   rep_cnt_d  [KEY_NUM];
  logic [KEY_NUM-1:0] key_long_q, key_long_d;
  logic [KEY_NUM-1:0] key_repeat_q, key_repeat_d;

  // Two-flop synchroniser for the asynchronous key pins.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = sync2_q ^ PIN_IDLE;

  // Debounce: accept a new level only after it persists DEBOUNCE_CYC cycles;
  // any cycle agreeing with the current state restarts the count.
  always_comb begin
    key_state_d   = key_state_q;
    key_press_d   = '0;
    key_release_d = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (pressed_s[i] == key_state_q[i]) begin
        db_cnt_d[i] = DB_ZERO;
      end else if (db_cnt_q[i] == DB_MAX) begin
        db_cnt_d[i]      = DB_ZERO;
        key_state_d[i]   = pressed_s[i];
        key_press_d[i]   = pressed_s[i];
        key_release_d[i] = ~pressed_s[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Hold FSM: the registered press pulse starts the long-press count, so
  // key_long lands LONG_CYC cycles after the key_press cycle. A release
  // (next debounced state low) returns to IDLE on the same edge, which
  // also suppresses any long/repeat pulse that would coincide with it.
  always_comb begin
    key_long_d   = '0;
    key_repeat_d = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      hold_st_d[i]  = hold_st_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      rep_cnt_d[i]  = rep_cnt_q[i];
      if (!key_state_d[i]) begin
        hold_st_d[i]  = ST_IDLE;
        hold_cnt_d[i] = LNG_ZERO;
        rep_cnt_d[i]  = REP_ZERO;
      end else begin
        case (hold_st_q[i])
          ST_IDLE: begin
            hold_cnt_d[i] = LNG_ZERO;
            rep_cnt_d[i]  = REP_ZERO;
            if (key_press_q[i]) begin
              hold_st_d[i]  = ST_HOLD;
              hold_cnt_d[i] = LNG_ONE;
            end else begin
              hold_st_d[i]  = ST_IDLE;
            end
          end
          ST_HOLD: begin
            if (hold_cnt_q[i] == LNG_MAX) begin
              key_long_d[i] = 1'b1;
              hold_cnt_d[i] = LNG_ZERO;
              rep_cnt_d[i]  = REP_ZERO;
              hold_st_d[i]  = ST_REPEAT;
            end else begin
              hold_cnt_d[i] = hold_cnt_q[i] + LNG_ONE;
            end
          end
          ST_REPEAT: begin
            if (rep_cnt_q[i] == REP_MAX) begin
              key_repeat_d[i] = 1'b1;
              rep_cnt_d[i]    = REP_ZERO;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
            end
          end
          default: begin
            hold_st_d[i]  = ST_IDLE;
            hold_cnt_d[i] = LNG_ZERO;
            rep_cnt_d[i]  = REP_ZERO;
          end
        endcase
      end
    end
  end

  // Debounce and hold state registers plus all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      key_state_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      key_long_q    <= '0;
      key_repeat_q  <= '0;
      for (int i = 0; i < KEY_NUM; i++) begin
        db_cnt_q[i]   <= DB_ZERO;
        hold_st_q[i]  <= ST_IDLE;
        hold_cnt_q[i] <= LNG_ZERO;
        rep_cnt_q[i]  <= REP_ZERO;
      end
    end else begin
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
      key_repeat_q  <= key_repeat_d;
      for (int i = 0; i < KEY_NUM; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_st_q[i]  <= hold_st_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        rep_cnt_q[i]  <= rep_cnt_d[i];
      end
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;
  assign key_repeat  = key_repeat_q;

endmodule
